// File: rtl/div_meter_if.sv
// div_meter_if: start/pin request side and busy/valid/timeout/div result side of the period meter.
interface div_meter_if;
  logic        start;
  logic        pin;
  logic        busy;
  logic        valid;
  logic        timeout;
  logic [23:0] div;
  modport master (output start, pin, input busy, valid, timeout, div);
  modport slave (input start, pin, output busy, valid, timeout, div);
endinterface

// File: rtl/div_meter.sv
// div_meter: measures the pin period in clk cycles as a 16.8 divider value.
// DIV_METER_CONTINUOUS_EN keeps measuring back-to-back windows until reset.
module div_meter #(
  parameter int          LOG2_EDGES = 8,
  parameter logic [31:0] TIMEOUT    = 32'hFFFF_FFFF
) (
  input  logic      clk,
  input  logic      reset,
  div_meter_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, ARM = 2'd1, MEAS = 2'd2;
  localparam logic [7:0] LAST = 8'((1 << LOG2_EDGES) - 1);
`ifdef DIV_METER_CONTINUOUS_EN
  localparam logic [1:0] AFTER_DONE = MEAS;
`else
  localparam logic [1:0] AFTER_DONE = IDLE;
`endif
  logic [1:0]  state;
  logic        s1, s2, prev;
  logic [31:0] cnt, cnt_inc;
  logic [7:0]  edge_cnt;
  logic        valid_q, tmo_q;
  logic [23:0] div_q;
  logic        rise, hit_to, done;
  logic [39:0] scaled;
  always_comb begin
    rise    = s2 & ~prev;
    hit_to  = state != IDLE && cnt == TIMEOUT;
    done    = state == MEAS && rise && edge_cnt == LAST && !hit_to;
    cnt_inc = &cnt ? cnt : cnt + 32'd1;
    scaled  = {8'd0, cnt} << (8 - LOG2_EDGES);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state    <= IDLE;
      s1       <= 1'b0;
      s2       <= 1'b0;
      prev     <= 1'b0;
      cnt      <= '0;
      edge_cnt <= '0;
      valid_q  <= 1'b0;
      tmo_q    <= 1'b0;
      div_q    <= '0;
    end else begin
      s1      <= bus.pin;
      s2      <= s1;
      prev    <= s2;
      valid_q <= done;
      tmo_q   <= hit_to;
      if (done) div_q <= |scaled[39:24] ? 24'hFF_FFFF : scaled[23:0];
      case (state)
        IDLE: if (bus.start) begin
          state <= ARM;
          cnt   <= '0;
        end
        ARM: if (hit_to) state <= IDLE;
        else if (rise) begin
          state    <= MEAS;
          cnt      <= 32'd1;
          edge_cnt <= '0;
        end else cnt <= cnt_inc;
        MEAS: if (hit_to) state <= IDLE;
        else if (done) begin
          // the completing rise opens the next window when running continuously
          state    <= AFTER_DONE;
          cnt      <= 32'd1;
          edge_cnt <= '0;
        end else begin
          cnt <= cnt_inc;
          if (rise) edge_cnt <= edge_cnt + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  assign bus.busy    = state != IDLE;
  assign bus.valid   = valid_q;
  assign bus.timeout = tmo_q;
  assign bus.div     = div_q;
endmodule

// File: doc/div_meter.md
Name: div_meter

Overview:
- Frequency/period meter: the inverse of the PIO clock divider.
- Measures the period of an external pin signal in system-clock cycles.
- Reports the result in the divider's 24-bit 16.8 fixed-point format, so the value can be fed straight back as a divider setting (clock recovery, baud auto-detect).
- Sits beside the PIO state machines on the system clock. Software-controlled via start/valid.

Parameters:
- LOG2_EDGES, 8: log2 of rising-edge intervals averaged per measurement; legal 0..8; result = total_cycles << (8 - LOG2_EDGES).
- TIMEOUT, 32'hFFFF_FFFF: cycle limit in ARM/MEASURE before abort; 32-bit.

Ports:
- clk  in  1  system clock, all logic on posedge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a measurement
- pin  in  1  asynchronous input signal to be measured
- busy  out  1  high while a measurement is in progress (ARM or MEASURE)
- valid  out  1  one-cycle pulse: div updated
- timeout  out  1  one-cycle pulse: measurement aborted
- div  out  24  measured period, 16.8 fixed point, registered, held between measurements

Behaviour:
- Reset (reset low, asynchronous):
  - State IDLE.
  - busy=0, valid=0, timeout=0, div=0.
  - Synchronizer, edge register and counters cleared.
- Input conditioning:
  - pin passes through a 2-FF synchronizer, then an edge register.
  - rise = sync & ~prev.
  - A pin rising edge produces a rise pulse 3 clk later; this latency is identical for every edge, so it cancels out of the measurement.
- State machine IDLE -> ARM -> MEASURE -> IDLE:
  - IDLE: start=1 -> ARM next cycle, cycle counter cleared. busy=0.
  - ARM: busy=1. Cycle counter increments each clk. On rise: counter := 1, edge_cnt := 0, go to MEASURE.
  - MEASURE: busy=1. Counter increments each clk. On rise, edge_cnt increments.
    - When rise occurs with edge_cnt == 2^LOG2_EDGES - 1, the total is the counter value in that cycle, i.e. the clk cycles between the first and the 2^LOG2_EDGES-th subsequent rise.
    - Next cycle: div <= scaled total, valid=1 for one cycle, state IDLE, busy=0.
- Arithmetic:
  - Counter is 32-bit and saturates at all-ones; it never wraps.
  - Scaled = total << (8 - LOG2_EDGES), computed in 40 bits.
  - If scaled > 24'hFFFFFF, div = 24'hFFFFFF (clamp).
  - Minimum meaningful result is 0x000200 (pin toggling every clk).
- Timeout:
  - In ARM or MEASURE, when the counter reaches TIMEOUT, go to IDLE next cycle.
  - timeout=1 for one cycle; div unchanged; valid stays 0.
  - Timeout has priority over a completing rise in the same cycle.
- Simultaneous events:
  - start while busy is ignored.
  - start in the same cycle that valid/timeout is pulsing (state already IDLE) is accepted.
- Reset mid-operation aborts immediately with no valid or timeout pulse.
- valid and timeout are never high together.

Optional Feature:
- DIV_METER_CONTINUOUS_EN defined:
  - After a completed measurement, go directly to MEASURE instead of IDLE.
  - The completing rise is reused as the first edge of the next window: counter := 1, edge_cnt := 0, with no lost cycles.
  - busy stays 1; valid pulses once per window.
  - A timeout still returns to IDLE.
  - start is ignored while running; reset is the only stop.
- Not defined: single-shot operation as described above.

Test Plan:
1. Default params, pin period 10 clk (50% duty), start pulse -> after 256 intervals, valid pulses once, div=24'h000A00, busy falls in the valid cycle.
2. LOG2_EDGES=1, pin periods alternating 7 and 8 clk -> div=24'h000780 (7.5 in 16.8).
3. TIMEOUT=1000, pin held low, start -> timeout pulses 1001..1002 clk after start, div keeps its prior value, valid never asserts.
4. LOG2_EDGES=0, pin period 70000 clk -> div=24'hFFFFFF (clamped, unscaled 17 920 000).
5. Reset asserted mid-MEASURE, then released; pin period 4 -> busy=0, div=0 and no pulses immediately. A new start then yields div=24'h000400.
6. start re-pulsed while busy -> ignored, a single valid only. With DIV_METER_CONTINUOUS_EN and period 10 -> valid every 2560 clk, div=24'h000A00 each time.
